decoder: RTL and testbench
==========================

DECODER -- requirements
Module: decoder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  begin one decode frame; honoured only in IDLE.
REQ-005 in  input  25  encoded slice; bit index i = 5*y + x.
REQ-006 ready  output  1  high only in IDLE.
REQ-007 putInput  output  1  high while input slices are being captured.
REQ-008 outReady  output  1  high while decoded slices are presented on out.
REQ-009 out  output  25  decoded slice; same bit indexing as in.

Function
REQ-010 A frame SHALL be COUNT = 64 slices of 25 bits, indexed by slice number z = 0..63.
REQ-011 The block SHALL implement an FSM with states IDLE, HOLD, LOAD, EMIT.
REQ-012 IDLE: when start = 1, the next state SHALL be HOLD.
REQ-013 HOLD: the FSM SHALL stay in HOLD while start = 1 and SHALL go to LOAD on the first cycle with start = 0.
REQ-014 LOAD: putInput SHALL be 1; on each rising edge, in SHALL be written to buffer slice z; z SHALL increment; after z = 63 is written, the next state SHALL be EMIT.
REQ-015 EMIT: outReady SHALL be 1; out SHALL equal decoded slice z; z SHALL increment each cycle; after z = 63 is presented, the next state SHALL be IDLE.
REQ-016 Decode rule, with B the buffer and A the output: A[u][v][z] = B[v][(2*(u - v)) mod 5][(z + R[u][v]) mod 64], where bit index = 5*y + x. This inverts the encoder's rho step followed by its pi step.
REQ-017 R, indexed 5*y + x, SHALL be: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
REQ-018 out SHALL be purely combinational from buffer contents and z, with zero added latency.
REQ-019 out SHALL be 0 whenever outReady = 0.
REQ-020 start SHALL be ignored in LOAD and EMIT; a new frame needs a return to IDLE.
REQ-021 Slice-counter arithmetic SHALL be 6-bit modulo-64; wrap from 63 to 0 SHALL coincide with the state exit.
REQ-022 Frame latency SHALL be: start sampled high -> HOLD; start low -> 64 LOAD cycles -> 64 EMIT cycles -> IDLE.
REQ-023 Buffer contents SHALL be fully overwritten in every LOAD; stale data SHALL never reach out in a completed frame.

Reset
REQ-024 When rst = 0 at a rising edge, the block SHALL set state = IDLE, z = 0, ready = 1, putInput = 0, outReady = 0, out = 0.
REQ-025 Reset asserted mid-LOAD or mid-EMIT SHALL abort the frame immediately; the next frame SHALL decode correctly.
REQ-026 The buffer SHALL need no reset.

Structure
REQ-027 A shared package SHALL hold COUNT = 64, SLICE_W = 25, the R offset table, and the state enum type.
REQ-028 One sub-module SHALL exist: decoder_slice_map. It is combinational; it takes the 64x25 buffer and z, and produces the decoded 25-bit slice per REQ-016.
REQ-029 The top SHALL contain the FSM, the counter, and the 64x25 register buffer.

Verification
REQ-030 Reset: hold rst = 0 for 2 cycles -> ready = 1, putInput = 0, outReady = 0, out = 0.
REQ-031 All-zero frame: 64 slices of 0 -> 64 output slices of 0; ready = 1 on the cycle after the last EMIT.
REQ-032 Single bit at slice 0, bit 0 (R = 0) -> output slice 0 = 25'h1; all other output slices = 0.
REQ-033 Single bit at slice 0, bit 1 (B[1][0]) -> output slice 20, bit 6 = 1 (A[1][1], R = 44); all other output bits = 0.
REQ-034 Abort and restart: rst = 0 at LOAD slice 30, then a full frame from REQ-032 -> REQ-032 result; start pulsed during LOAD/EMIT -> no effect.
REQ-035 Random frames: output SHALL match a reference model of REQ-016, and re-encoding the output with rho then pi SHALL reproduce the input bit-exactly.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants, rho offset table and FSM state type for the slice decoder.
package decoder_pkg;
  localparam int COUNT   = 64;
  localparam int SLICE_W = 25;
  localparam int Z_W     = 6;

  // Rotation offsets, indexed 5*y + x.
  localparam int R_TAB [SLICE_W] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LOAD, S_EMIT} state_t;

  // Buffer bit index feeding output lane (u, v): B[v][(2*(u-v)) mod 5].
  function automatic int src_bit(input int u, input int v);
    return 5 * ((2 * (u - v) + 10) % 5) + v;
  endfunction
endpackage

// File: rtl/decoder_slice_map.sv
// Combinational inverse pi/rho: gathers decoded slice z from the frame buffer.
module decoder_slice_map
  import decoder_pkg::*;
(
  input  logic [COUNT-1:0][SLICE_W-1:0] i_mem,
  input  logic [Z_W-1:0]                i_z,
  output logic [SLICE_W-1:0]            o_slice
);
  for (genvar v = 0; v < 5; v++) begin : g_y
    for (genvar u = 0; u < 5; u++) begin : g_x
      localparam int          SB = src_bit(u, v);
      localparam logic [Z_W-1:0] RO = Z_W'(R_TAB[5*v+u]);
      logic [Z_W-1:0] w_zz;
      // 6-bit add gives the mod-64 rotation for free.
      assign w_zz             = i_z + RO;
      assign o_slice[5*v+u]   = i_mem[w_zz][SB];
    end
  end
endmodule

// File: rtl/decoder.sv
// Frame decoder: captures 64 encoded slices, then emits 64 decoded slices.
module decoder
  import decoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SLICE_W-1:0] in,
  output logic               ready,
  output logic               putInput,
  output logic               outReady,
  output logic [SLICE_W-1:0] out
);
  state_t                        r_state, w_next;
  logic [Z_W-1:0]                r_z;
  logic [COUNT-1:0][SLICE_W-1:0] r_mem;
  logic [SLICE_W-1:0]            w_slice;
  logic                          w_last;

  assign w_last = (r_z == Z_W'(COUNT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_z     <= '0;
    end else begin
      r_state <= w_next;
      // Counter wraps 63->0 on the same edge that leaves LOAD/EMIT.
      if (r_state == S_LOAD || r_state == S_EMIT) r_z <= r_z + 1'b1;
      else                                        r_z <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) r_mem[r_z] <= in;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start)  w_next = S_HOLD;
      S_HOLD: if (!start) w_next = S_LOAD;
      S_LOAD: if (w_last) w_next = S_EMIT;
      S_EMIT: if (w_last) w_next = S_IDLE;
      default:            w_next = S_IDLE;
    endcase
  end

  decoder_slice_map u_map (
    .i_mem   (r_mem),
    .i_z     (r_z),
    .o_slice (w_slice)
  );

  assign ready    = (r_state == S_IDLE);
  assign putInput = (r_state == S_LOAD);
  assign outReady = (r_state == S_EMIT);
  assign out      = outReady ? w_slice : '0;
endmodule

// File: tb/tb_decoder.sv
// Directed and random-frame checks for the slice decoder.
module tb_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] in;
  logic        ready, putInput, outReady;
  logic [24:0] out;

  int n_vec = 0;
  int n_bad = 0;

  logic [24:0] f_in  [64];
  logic [24:0] f_out [64];
  logic [24:0] f_exp [64];

  int RT [25] = '{0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39,
                  41,45,15,21,8, 18,2,61,56,14};

  decoder dut (
    .clk(clk), .rst(rst), .start(start), .in(in),
    .ready(ready), .putInput(putInput), .outReady(outReady), .out(out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int z = 0; z < 64; z++) begin
      f_in[z]  = '0;
      f_exp[z] = '0;
    end
  endtask

  // Drives one complete frame from IDLE, capturing the emitted slices.
  task automatic run_frame(input int hold_n, input bit pulse);
    start = 1'b1;
    for (int i = 0; i < hold_n; i++) begin
      step();
      n_vec++;
      if (ready !== 1'b0 || putInput !== 1'b0) begin
        n_bad++;
        $display("FAIL hold: ready=%b putInput=%b, want 0 0", ready, putInput);
      end
    end
    start = 1'b0;
    step();
    for (int z = 0; z < 64; z++) begin
      in    = f_in[z];
      start = pulse && (z == 10);
      n_vec++;
      if (putInput !== 1'b1 || outReady !== 1'b0 || out !== '0) begin
        n_bad++;
        $display("FAIL load z=%0d: putInput=%b outReady=%b out=%h, want 1 0 0",
                 z, putInput, outReady, out);
      end
      step();
    end
    start = 1'b0;
    for (int z = 0; z < 64; z++) begin
      start = pulse && (z == 5);
      n_vec++;
      if (outReady !== 1'b1 || putInput !== 1'b0 || ready !== 1'b0) begin
        n_bad++;
        $display("FAIL emit z=%0d: outReady=%b putInput=%b ready=%b, want 1 0 0",
                 z, outReady, putInput, ready);
      end
      f_out[z] = out;
      step();
    end
    start = 1'b0;
    n_vec++;
    if (ready !== 1'b1 || outReady !== 1'b0 || out !== '0) begin
      n_bad++;
      $display("FAIL frame_end: ready=%b outReady=%b out=%h, want 1 0 0",
               ready, outReady, out);
    end
  endtask

  task automatic check_out(input string name);
    for (int z = 0; z < 64; z++) begin
      n_vec++;
      if (f_out[z] !== f_exp[z]) begin
        n_bad++;
        $display("FAIL %s slice %0d: got %h, want %h", name, z, f_out[z], f_exp[z]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; in = '0;
    step(); step();
    n_vec++;
    if (ready !== 1'b1 || putInput !== 1'b0 || outReady !== 1'b0 || out !== '0) begin
      n_bad++;
      $display("FAIL reset: ready=%b putInput=%b outReady=%b out=%h, want 1 0 0 0",
               ready, putInput, outReady, out);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_reset: ready=%b, want 1", ready);
    end
  endtask

  task automatic test_single_bit0();
    clear_frame();
    f_in[0]  = 25'h1;
    f_exp[0] = 25'h1;
    run_frame(1, 1'b0);
    check_out("single_bit0");
  endtask

  task automatic test_single_bit1();
    clear_frame();
    f_in[0]   = 25'h2;
    f_exp[20] = 25'h40;
    run_frame(3, 1'b0);
    check_out("single_bit1");
  endtask

  task automatic test_abort_restart();
    clear_frame();
    for (int z = 0; z < 64; z++) f_in[z] = 25'h1ffffff;
    start = 1'b1; step(); start = 1'b0; step();
    for (int z = 0; z < 30; z++) begin
      in = f_in[z];
      step();
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (ready !== 1'b1 || putInput !== 1'b0 || outReady !== 1'b0 || out !== '0) begin
      n_bad++;
      $display("FAIL abort: ready=%b putInput=%b outReady=%b out=%h, want 1 0 0 0",
               ready, putInput, outReady, out);
    end
    rst = 1'b1;
    step();
    clear_frame();
    f_in[0]  = 25'h1;
    f_exp[0] = 25'h1;
    run_frame(2, 1'b1);
    check_out("abort_restart");
  endtask

  task automatic test_random();
    logic [24:0] enc;
    for (int f = 0; f < 2; f++) begin
      for (int z = 0; z < 64; z++) f_in[z] = 25'($urandom);
      for (int z = 0; z < 64; z++)
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++)
            f_exp[z][5*y+x] = f_in[(z + RT[5*y+x]) % 64][5*((2*(x-y)+10)%5)+y];
      run_frame(1, 1'b0);
      check_out("random_model");
      // Re-encode: rho rotates lane (x,y) by R, pi moves it to (y, 2x+3y).
      for (int z = 0; z < 64; z++) begin
        enc = '0;
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++)
            enc[5*((2*x+3*y)%5)+y] = f_out[(z - RT[5*y+x] + 64) % 64][5*y+x];
        n_vec++;
        if (enc !== f_in[z]) begin
          n_bad++;
          $display("FAIL reencode slice %0d: got %h, want %h", z, enc, f_in[z]);
        end
      end
    end
  endtask

  task automatic test_zero_frame();
    clear_frame();
    run_frame(1, 1'b0);
    check_out("zero_frame");
  endtask

  initial begin
    test_reset();
    test_single_bit0();
    test_single_bit1();
    test_abort_restart();
    test_random();
    test_zero_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
